// File: rtl/seg_bin2bcd_ctrl_pkg.sv
// seg_pkg: shared constants and state type for the seven-segment BCD controller
package seg_pkg;
    localparam int SEG_DIGITS = 6;
    localparam logic [3:0] SEG_BLANK = 4'hF;
    localparam int unsigned SEG_MAX_DEC = 999999;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} seg_state_t;
endpackage

// File: rtl/seg_bin2bcd_ctrl_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the digit is 5 or more
//   d : BCD nibble before the shift
//   q : corrected nibble
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/seg_bin2bcd_ctrl.sv
// seg_bin2bcd_ctrl: sequential binary to six-digit BCD converter feeding a display scan driver
//   clk, rst_n       : clock, asynchronous active-low reset
//   bin_in, dp_in    : value and decimal-point mask, taken when in_valid && in_ready
//   num, point       : packed BCD digits and point mask, held between completions
//   upd              : one-cycle pulse when num/point/ovf are refreshed
//   ovf              : last accepted value was above 999999
//   SEG_LZB_EN       : define to blank leading zero digits (code 4'hF, point off)
module seg_bin2bcd_ctrl
    import seg_pkg::*;
#(
    parameter int BIN_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic [5:0]       dp_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [23:0]      num,
    output logic [5:0]       point,
    output logic             upd,
    output logic             ovf
);
    seg_state_t state_q, state_d;
    logic [23:0] bcd_q, bcd_adj, num_d;
    logic [19:0] bin_q, bin_ext;
    logic [5:0]  dp_q, point_d;
    logic [4:0]  cnt_q;
    logic        big_q;
`ifdef SEG_LZB_EN
    logic        lead;
`endif

    assign bin_ext  = 20'(bin_in);
    assign in_ready = (state_q == IDLE);

    for (genvar i = 0; i < SEG_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (.d(bcd_q[4*i+:4]), .q(bcd_adj[4*i+:4]));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = (state_q == IDLE && in_valid)         ? SHIFT :
                  (state_q == SHIFT && cnt_q == 5'd19)  ? DONE  :
                  (state_q == DONE)                     ? IDLE  : state_q;
    end

    // Out-of-range values still run the full shift so latency is fixed; the
    // truncated BCD is simply replaced by 999999 at completion.
    always_comb begin
        num_d   = big_q ? 24'h999999 : bcd_q;
        point_d = dp_q;
`ifdef SEG_LZB_EN
        lead = !big_q;
        for (int k = SEG_DIGITS - 1; k > 0; k--) begin
            lead = lead && (num_d[4*k+:4] == 4'h0);
            if (lead) begin
                num_d[4*k+:4] = SEG_BLANK;
                point_d[k]    = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bcd_q <= '0;
            bin_q <= '0;
            dp_q  <= '0;
            big_q <= 1'b0;
            cnt_q <= '0;
            num   <= '0;
            point <= '0;
            ovf   <= 1'b0;
            upd   <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (state_q == IDLE && in_valid) begin
                bcd_q <= '0;
                bin_q <= bin_ext;
                dp_q  <= dp_in;
                big_q <= 32'(bin_ext) > SEG_MAX_DEC;
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                {bcd_q, bin_q} <= {bcd_adj[22:0], bin_q, 1'b0};
                cnt_q          <= cnt_q + 5'd1;
            end else if (state_q == DONE) begin
                num   <= num_d;
                point <= point_d;
                ovf   <= big_q;
                upd   <= 1'b1;
            end
        end
endmodule

// File: tb/tb_seg_bin2bcd_ctrl.sv
// tb_seg_bin2bcd_ctrl: randomized self-checking bench against an arithmetic decimal model
module tb_seg_bin2bcd_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] bin_in = '0;
    logic [5:0]  dp_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] num;
    logic [5:0]  point;
    logic        upd;
    logic        ovf;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_bin2bcd_ctrl #(.BIN_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .dp_in(dp_in),
        .in_valid(in_valid), .in_ready(in_ready), .num(num),
        .point(point), .upd(upd), .ovf(ovf)
    );

    function automatic logic [23:0] exp_num(input int unsigned v);
        logic [23:0] r;
        r = '0;
        if (v > 999999) return 24'h999999;
        for (int k = 0; k < 6; k++) begin
            r[4*k+:4] = 4'((v / (10 ** k)) % 10);
`ifdef SEG_LZB_EN
            if (k > 0 && v < 10 ** k) r[4*k+:4] = 4'hF;
`endif
        end
        return r;
    endfunction

    function automatic logic [5:0] exp_point(input int unsigned v, input logic [5:0] dp);
        logic [5:0] r;
        r = dp;
`ifdef SEG_LZB_EN
        for (int k = 1; k < 6; k++)
            if (v <= 999999 && v < 10 ** k) r[k] = 1'b0;
`endif
        return r;
    endfunction

    task automatic run_conv(input logic [19:0] v, input logic [5:0] dp, input bit hold, input string tag);
        logic [23:0] en;
        logic [5:0]  ep;
        logic        eo;
        int          busy_bad;
        en = exp_num(v);
        ep = exp_point(v, dp);
        eo = (v > 20'd999999);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_idle got %b want 1", tag, in_ready);
        end
        bin_in = v;
        dp_in = dp;
        in_valid = 1'b1;
        @(posedge clk);
        busy_bad = 0;
        for (int e = 1; e <= 21; e++) begin
            @(negedge clk);
            if (hold) begin
                bin_in = 20'($urandom);
                dp_in = 6'($urandom);
            end else in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (e < 21 && (in_ready !== 1'b0 || upd !== 1'b0)) busy_bad++;
        end
        vectors++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy got %0d bad cycles want 0", tag, busy_bad);
        end
        vectors++;
        if ({num, point, ovf, upd} !== {en, ep, eo, 1'b1}) begin
            errors++;
            $display("FAIL %s result got num=%h point=%b ovf=%b upd=%b want num=%h point=%b ovf=%b upd=1",
                     tag, num, point, ovf, upd, en, ep, eo);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (upd !== 1'b0 || in_ready !== 1'b1 || num !== en || ovf !== eo) begin
            errors++;
            $display("FAIL %s hold got upd=%b ready=%b num=%h ovf=%b want upd=0 ready=1 num=%h ovf=%b",
                     tag, upd, in_ready, num, ovf, en, eo);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (num !== 24'h0) begin errors++; $display("FAIL reset_num got %h want 000000", num); end
        vectors++;
        if (point !== 6'h0) begin errors++; $display("FAIL reset_point got %b want 000000", point); end
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        vectors++;
        if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", upd); end
        vectors++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    endtask

    task automatic test_directed();
        run_conv(20'd123456, 6'b000100, 1'b0, "dir_123456");
        run_conv(20'd42, 6'b100001, 1'b0, "dir_42");
        run_conv(20'd0, 6'b111111, 1'b0, "dir_0");
        run_conv(20'd1000000, 6'b010101, 1'b0, "dir_ovf");
        run_conv(20'd7, 6'b000000, 1'b0, "dir_ovf_clear");
        run_conv(20'd999999, 6'b100000, 1'b0, "dir_max");
        run_conv(20'd1048575, 6'b000011, 1'b0, "dir_allones");
        run_conv(20'd100000, 6'b111111, 1'b0, "dir_100000");
    endtask

    task automatic test_random();
        logic [19:0] v;
        for (int n = 0; n < 16; n++) begin
            case (n % 4)
                0:       v = 20'($urandom_range(0, 9));
                1:       v = 20'($urandom_range(10, 9999));
                2:       v = 20'($urandom_range(10000, 999999));
                default: v = 20'($urandom_range(0, 1048575));
            endcase
            run_conv(v, 6'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_conv(20'($urandom_range(0, 999999)), 6'($urandom), 1'b1, "busy_hold_a");
        run_conv(20'($urandom_range(0, 1048575)), 6'($urandom), 1'b1, "busy_hold_b");
    endtask

    task automatic test_reset_abort();
        int bad;
        run_conv(20'd654321, 6'b000010, 1'b0, "pre_abort");
        @(negedge clk);
        bin_in = 20'd31415;
        dp_in = 6'b111000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({num, point, ovf, upd, in_ready} !== {24'h0, 6'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL abort_reset got num=%h point=%b ovf=%b upd=%b ready=%b want 000000 000000 0 0 1",
                     num, point, ovf, upd, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", in_ready); end
        bad = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (upd !== 1'b0 || num !== 24'h0) bad++;
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL abort_quiet got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
